// File: rtl/uart_tx_fifo_if.sv
// Byte-write side and transmitter handshake of the UART TX FIFO, bundled with
// producer (master) and FIFO (slave) views.
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   level;
  logic                  tx_ready;
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic                  ovf;
  logic                  ovf_clr;

  modport master (
    output wr_en, wr_data, tx_ready, ovf_clr,
    input  full, empty, level, tx_data, tx_start, ovf
  );

  modport slave (
    input  wr_en, wr_data, tx_ready, ovf_clr,
    output full, empty, level, tx_data, tx_start, ovf
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding the UART transmitter through a data/start/ready handshake.
// Define UART_TX_FIFO_OVF_EN to enable the sticky overflow flag (ovf/ovf_clr).
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  tx_start_q, tx_start_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  ovf_q, ovf_d;
  logic                  wr_accept;
  logic                  pop;

  // Full is the registered pre-edge flag, so a same-cycle pop never frees room.
  assign wr_accept = bus.wr_en && !full_q;
  assign pop       = (state_q == IDLE) && !empty_q && bus.tx_ready;

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d    = LAUNCH;
          tx_start_d = 1'b1;
        end
      end
      LAUNCH: state_d = BUSY;
      BUSY: begin
        if (bus.tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    tx_data_d = tx_data_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      tx_data_d = mem_q[rd_ptr_q];
    end
    case ({wr_accept, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == FULL_LVL);
    empty_d = (level_d == '0);
  end

`ifdef UART_TX_FIFO_OVF_EN
  // Set takes priority so an overflow coinciding with a clear is not lost.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.ovf_clr) ovf_d = 1'b0;
    if (bus.wr_en && full_q) ovf_d = 1'b1;
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = bus.ovf_clr;

  always_comb begin
    ovf_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.level    = level_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model (20-cycle frames).
module tb_uart_tx_fifo;

  localparam int FRAME = 20;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  logic       force_rdy;
  logic       rdy_val;
  int         busy_cnt;
  logic       model_rdy;
  logic       prev_start;
  logic [7:0] got [$];

  uart_tx_fifo_if #(.DEPTH_LOG2(4)) bus ();

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter: ready while idle and on the last cycle of its frame.
  always @(posedge clk) begin
    if (bus.tx_start) busy_cnt <= FRAME;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign model_rdy    = (busy_cnt <= 1) && !bus.tx_start;
  assign bus.tx_ready = force_rdy ? rdy_val : model_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.tx_start === 1'b1) begin
      got.push_back(bus.tx_data);
      chk("start_dbl", 32'(prev_start), 32'd0);
      if (!force_rdy) chk("start_in_frame", 32'(busy_cnt > 1), 32'd0);
    end
    prev_start = bus.tx_start;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = first + 8'(i);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_launches(input string tag, input int n, input int bound);
    int k = 0;
    while (got.size() < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(got.size()), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_b;
    n_chk = 0;
    n_err = 0;
    busy_cnt = 0;
    prev_start = 1'b0;
    force_rdy = 1'b0;
    rdy_val = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.ovf_clr = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_start", 32'(bus.tx_start), 32'd0);
    chk("rst_data", 32'(bus.tx_data), 32'h00);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Single byte: tx_start two edges after wr_en is presented.
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hA5;
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("one_level1", 32'(bus.level), 32'd1);
    chk("one_empty0", 32'(bus.empty), 32'd0);
    chk("one_start_early", 32'(bus.tx_start), 32'd0);
    @(negedge clk);
    chk("one_start", 32'(bus.tx_start), 32'd1);
    chk("one_data", 32'(bus.tx_data), 32'hA5);
    chk("one_level0", 32'(bus.level), 32'd0);
    chk("one_empty1", 32'(bus.empty), 32'd1);
    @(negedge clk);
    chk("one_start_pulse", 32'(bus.tx_start), 32'd0);
    chk("one_data_hold", 32'(bus.tx_data), 32'hA5);
    cyc(FRAME + 5);
    chk("one_count", 32'(got.size()), 32'd1);

    // Burst to full with the transmitter held off, then overflow.
    got.delete();
    force_rdy = 1'b1;
    rdy_val = 1'b0;
    burst(8'h01, 16);
    chk("burst_full", 32'(bus.full), 32'd1);
    chk("burst_level", 32'(bus.level), 32'd16);
    chk("burst_empty", 32'(bus.empty), 32'd0);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hFF;
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("ovf_level", 32'(bus.level), 32'd16);
    chk("ovf_full", 32'(bus.full), 32'd1);
`ifdef UART_TX_FIFO_OVF_EN
    chk("ovf_set", 32'(bus.ovf), 32'd1);
    @(negedge clk);
    chk("ovf_sticky", 32'(bus.ovf), 32'd1);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hEE;
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("ovf_set_wins", 32'(bus.ovf), 32'd1);
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    chk("ovf_clr", 32'(bus.ovf), 32'd0);
`else
    chk("ovf_off", 32'(bus.ovf), 32'd0);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    chk("ovf_off_clr", 32'(bus.ovf), 32'd0);
`endif
    chk("ovf_no_launch", 32'(got.size()), 32'd0);
    force_rdy = 1'b0;
    wait_launches("burst_launches", 16, 1000);
    for (int i = 0; i < 16; i++) begin
      exp_b = 8'h01 + 8'(i);
      chk("burst_order", (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_b));
    end
    cyc(FRAME + 5);
    chk("burst_extra", 32'(got.size()), 32'd16);
    chk("burst_drained", 32'(bus.empty), 32'd1);

    // Simultaneous write and pop at level 3, 40 pairs to wrap the pointers.
    got.delete();
    force_rdy = 1'b1;
    rdy_val = 1'b0;
    burst(8'h30, 3);
    chk("pair_pre_level", 32'(bus.level), 32'd3);
    for (int i = 0; i < 40; i++) begin
      rdy_val = 1'b1;
      bus.wr_en = 1'b1;
      bus.wr_data = 8'h40 + 8'(i);
      @(negedge clk);
      rdy_val = 1'b0;
      bus.wr_en = 1'b0;
      if (i == 0) chk("pair_level_first", 32'(bus.level), 32'd3);
      @(negedge clk);
      rdy_val = 1'b1;
      @(negedge clk);
    end
    rdy_val = 1'b0;
    chk("pair_level_last", 32'(bus.level), 32'd3);
    chk("pair_launches", 32'(got.size()), 32'd40);
    force_rdy = 1'b0;
    wait_launches("pair_drain", 43, 500);
    for (int i = 0; i < 43; i++) begin
      exp_b = (i < 3) ? 8'h30 + 8'(i) : 8'h40 + 8'(i - 3);
      chk("pair_order", (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_b));
    end
    cyc(FRAME + 5);
    chk("pair_empty", 32'(bus.empty), 32'd1);

    // Asynchronous reset while BUSY with five bytes queued.
    got.delete();
    burst(8'h50, 6);
    chk("rstmid_level", 32'(bus.level), 32'd5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_start", 32'(bus.tx_start), 32'd0);
    chk("rstmid_level0", 32'(bus.level), 32'd0);
    chk("rstmid_empty", 32'(bus.empty), 32'd1);
    chk("rstmid_full", 32'(bus.full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    got.delete();
    cyc(FRAME + 20);
    chk("rstmid_quiet", 32'(got.size()), 32'd0);
    chk("rstmid_still_empty", 32'(bus.empty), 32'd1);

    // Ready held low for 100 cycles with 4 bytes queued.
    force_rdy = 1'b1;
    rdy_val = 1'b0;
    burst(8'h61, 4);
    cyc(100);
    chk("hold_no_launch", 32'(got.size()), 32'd0);
    chk("hold_level", 32'(bus.level), 32'd4);
    rdy_val = 1'b1;
    @(negedge clk);
    rdy_val = 1'b0;
    chk("hold_start", 32'(bus.tx_start), 32'd1);
    chk("hold_data", 32'(bus.tx_data), 32'h61);
    cyc(20);
    chk("hold_one_launch", 32'(got.size()), 32'd1);
    chk("hold_level3", 32'(bus.level), 32'd3);
    rdy_val = 1'b1;
    @(negedge clk);
    rdy_val = 1'b0;
    cyc(5);
    chk("hold_idle_wait", 32'(got.size()), 32'd1);
    force_rdy = 1'b0;
    wait_launches("hold_drain", 4, 300);
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'h61 + 8'(i);
      chk("hold_order", (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_b));
    end
    cyc(FRAME + 5);
    chk("hold_empty", 32'(bus.empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
